// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial unsigned adder controller.
// Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
// All of the arithmetic goes through one 1-bit full_adder instance.
//
// Ports:
//   clk    in   clock; all state updates on its rising edge
//   rst    in   synchronous, active-high reset
//   start  in   begin an addition (looked at only in IDLE)
//   a, b   in   WIDTH-bit addends, captured when start is accepted
//   c_in   in   carry-in, captured when start is accepted
//   busy   out  high while bits are being added (RUN)
//   done   out  one-cycle pulse: sum/c_out hold a new result (DONE)
//   sum    out  registered (a+b+c_in) mod 2^WIDTH
//   c_out  out  registered carry out of bit WIDTH-1
//
// Timing: if start is accepted at edge k, done is high in the cycle after
// edge k+WIDTH. With start held high, a new result appears every WIDTH+2
// cycles.

module full_adder (
  output logic s,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .s     (fa_s),
    .c_out (fa_c),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry)
  );

  // Flags come straight from the state register, so they are glitch-free
  // and can never be high together.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          // Result bits enter at the MSB; after WIDTH shifts bit 0 of the
          // sum has reached psum[0].
          psum  <= {fa_s, psum[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // The last bit is still on the adder output, so the completed
            // result is assembled here rather than read from psum.
            sum   <= {fa_s, psum[WIDTH-1:1]};
            c_out <= fa_c;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl. The stimulus process pushes the
// expected {c_out,sum} and the cycle on which done must appear; the monitor
// pops and compares whenever done is seen. A WIDTH=8 instance takes the
// directed vectors and a strided sweep; a WIDTH=4 instance is swept over
// every (a, b, c_in) combination.

module tb_serial_add_ctrl;
  typedef struct { logic [8:0] res; int cyc; } exp8_t;
  typedef struct { logic [4:0] res; int cyc; } exp4_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0;
  logic       busy, done, c_out;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c_in4 = 1'b0;
  logic       busy4, done4, c_out4;
  logic [3:0] sum4;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp8_t q8[$];
  exp4_t q4[$];
  logic fin = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic       chk_rst = 1'b0;
  logic       fin_chk = 1'b0;
  int         bcnt = 0, bcnt4 = 0;
  logic [8:0] last8 = '0;
  logic [4:0] last4 = '0;

  always @(negedge clk) begin
    exp8_t e8;
    exp4_t e4;
    if (chk_rst) begin
      n_vec++;
      if (busy || done || sum != 8'h00 || c_out || busy4 || done4 || sum4 != 4'h0 || c_out4) begin
        n_err++;
        $display("FAIL reset_state: busy=%0b done=%0b sum=%h c_out=%0b busy4=%0b done4=%0b sum4=%h c_out4=%0b, want all 0",
                 busy, done, sum, c_out, busy4, done4, sum4, c_out4);
      end
    end
    chk_rst = rst;
    if (rst) begin
      bcnt = 0; bcnt4 = 0; last8 = '0; last4 = '0;
    end else begin
      // WIDTH=8 instance
      if (busy) begin
        if (bcnt == 0) begin
          n_vec++;
          if ({c_out, sum} !== last8) begin
            n_err++;
            $display("FAIL hold8 @%0d: {c_out,sum}=%h want %h", cyc, {c_out, sum}, last8);
          end
        end
        bcnt++;
      end
      if (done) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done8 @%0d: done=1 with no result expected", cyc);
        end else begin
          e8 = q8.pop_front();
          n_vec++;
          if ({c_out, sum} !== e8.res || cyc != e8.cyc || bcnt != 8 || busy) begin
            n_err++;
            $display("FAIL result8: got {c_out,sum}=%h cyc=%0d busy_cycles=%0d busy=%0b, want %h cyc=%0d busy_cycles=8 busy=0",
                     {c_out, sum}, cyc, bcnt, busy, e8.res, e8.cyc);
          end
          last8 = e8.res;
        end
        bcnt = 0;
      end
      // WIDTH=4 instance
      if (busy4) begin
        if (bcnt4 == 0) begin
          n_vec++;
          if ({c_out4, sum4} !== last4) begin
            n_err++;
            $display("FAIL hold4 @%0d: {c_out,sum}=%h want %h", cyc, {c_out4, sum4}, last4);
          end
        end
        bcnt4++;
      end
      if (done4) begin
        if (q4.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_done4 @%0d: done=1 with no result expected", cyc);
        end else begin
          e4 = q4.pop_front();
          n_vec++;
          if ({c_out4, sum4} !== e4.res || cyc != e4.cyc || bcnt4 != 4 || busy4) begin
            n_err++;
            $display("FAIL result4: got {c_out,sum}=%h cyc=%0d busy_cycles=%0d busy=%0b, want %h cyc=%0d busy_cycles=4 busy=0",
                     {c_out4, sum4}, cyc, bcnt4, busy4, e4.res, e4.cyc);
          end
          last4 = e4.res;
        end
        bcnt4 = 0;
      end
    end
    if (fin && !fin_chk) begin
      fin_chk = 1'b1;
      n_vec++;
      if (q8.size() != 0 || q4.size() != 0) begin
        n_err++;
        $display("FAIL missing_done: pending8=%0d pending4=%0d, want 0 0", q8.size(), q4.size());
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered just after an edge with the WIDTH=8 instance idle; returns the
  // same way. glitch: RUN cycle in which a foreign start is pulsed (0=none).
  // rst_at: RUN cycle in which rst is raised (0=none, aborts the add).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                      input logic [8:0] texp, input int glitch, input int rst_at);
    int k;
    a = ta; b = tb_; c_in = tci; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    if (rst_at == 0) q8.push_back('{texp, k + 8});
    start = 1'b0; a = ~ta; b = ~tb_; c_in = ~tci;
    for (int i = 1; i <= 9; i++) begin
      if (i == glitch) begin
        start = 1'b1; a = 8'h11; b = 8'h22; c_in = 1'b1;
      end else start = 1'b0;
      if (i == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (i == rst_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // directed vectors, hand-computed results
    run8(8'h00, 8'h00, 1'b0, 9'h000, 0, 0);
    run8(8'hFF, 8'h01, 1'b0, 9'h100, 0, 0);
    run8(8'hA5, 8'h5A, 1'b1, 9'h100, 0, 0);
    run8(8'h7F, 8'h80, 1'b0, 9'h0FF, 0, 0);
    run8(8'h3C, 8'h0F, 1'b1, 9'h04C, 3, 0);   // start pulsed mid-run: ignored
    run8(8'h12, 8'h34, 1'b0, 9'h046, 0, 4);   // reset in RUN cycle 4: aborted
    run8(8'h12, 8'h34, 1'b0, 9'h046, 0, 0);   // follow-up completes normally
    run8(8'h80, 8'h80, 1'b1, 9'h101, 0, 0);

    // start held high: results at k+8, k+18, k+28
    a = 8'hC8; b = 8'h64; c_in = 1'b1; start = 1'b1;
    k = cyc + 1;
    q8.push_back('{9'h12D, k + 8});
    q8.push_back('{9'h12D, k + 18});
    q8.push_back('{9'h12D, k + 28});
    repeat (21) @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // strided sweep on the WIDTH=8 instance against the reference sum
    for (int ai = 0; ai < 256; ai += 15)
      for (int bi = 0; bi < 256; bi += 17)
        for (int ci = 0; ci < 2; ci++)
          run8(8'(ai), 8'(bi), 1'(ci), 9'(ai + bi + ci), 0, 0);

    // every combination on the WIDTH=4 instance
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); c_in4 = 1'(ci); start4 = 1'b1;
          @(posedge clk); #1;
          q4.push_back('{5'(ai + bi + ci), cyc + 4});
          start4 = 1'b0; a4 = ~a4; b4 = ~b4; c_in4 = ~c_in4;
          repeat (5) @(posedge clk);
          #1;
        end

    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
